p3_exmem_elastic: RTL
=====================

Name: p3_exmem_elastic

Overview:
- Parametrised, elastic EX/MEM pipeline stage register.
- Carries the EX-stage bundle to MEM: type, rs1, rs2, rd, imm and store data.
- Replaces the single-stall register with a valid/ready handshake, a 2-entry skid buffer (in_ready is registered and does not depend on out_ready), synchronous flush, and a saturating stall-cycle counter.
- Empty slots always present BUBBLE_TYPE downstream, so MEM logic without valid-awareness stays safe.

Parameters:
XLEN, 32, width of rs1/rs2/imm/store payload fields
TYPE_W, 3, width of instruction type field
REG_W, 5, width of destination register index
BUBBLE_TYPE, 7, type code driven when stage is empty (must fit TYPE_W)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  EX offers a bundle
in_ready  out  1  stage can accept (registered)
in_type  in  TYPE_W  instruction type
in_rs1  in  XLEN  operand 1 / ALU result
in_rs2  in  XLEN  operand 2
in_rd  in  REG_W  destination register
in_imm  in  XLEN  immediate
in_store  in  XLEN  store data (post-forwarding mux)
out_valid  out  1  bundle presented to MEM
out_ready  in  1  MEM accepts
stall  in  1  hazard hold; effective accept = out_ready & ~stall
flush  in  1  synchronous kill of all held bundles
out_type  out  TYPE_W  type, BUBBLE_TYPE when out_valid=0
out_rs1, out_rs2, out_imm, out_store  out  XLEN  payload
out_rd  out  REG_W  destination, 0 when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and accept=0, saturating

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each with a valid bit.
- Reset (reset=0, async): M.v=S.v=0, in_ready=1, out_type=BUBBLE_TYPE, all other payload outputs 0, stall_cnt=0. Reset mid-transfer discards all held data. Deassertion is sampled on clock.
- Definitions: acc = out_ready & ~stall; push = in_valid & in_ready; pop = M.v & acc.
- out_valid = M.v. in_ready = ~S.v, registered.
- Priority per clock edge: flush > normal update.
  - flush=1: M.v=S.v=0, outputs forced to bubble (type=BUBBLE_TYPE, rd=0, data 0), in_ready=1 next cycle. A same-cycle push is dropped. stall_cnt unchanged.
  - M empty, push: M <= input. Latency 1 cycle, in to out.
  - M full, pop, S empty, push: M <= input (throughput 1/cycle).
  - M full, pop, S full: M <= S, S.v=0, in_ready=1 next cycle. No push is possible since in_ready=0.
  - M full, no pop, push: S <= input, in_ready=0 next cycle.
  - M full, pop, no push, S empty: M.v=0, outputs go to bubble.
  - Otherwise: hold.
- Order: bundles exit strictly in acceptance order; no duplication, no loss except on flush/reset.
- stall_cnt: increments when M.v=1 and acc=0; saturates at 2^CNT_W-1; cleared only by reset.
- Bubble outputs: whenever M.v=0 the outputs are registered bubble values, not stale data.
- Payload widths: fields pass unmodified; no arithmetic on payload.

Test Plan:
- Reset: assert reset=0 mid-stream with 2 bundles held -> immediately out_valid=0, out_type=7, out_rs1=0, in_ready=1, stall_cnt=0.
- Streaming: in_valid=1 for 4 cycles, out_ready=1, rs1=1..4 -> out_rs1=1,2,3,4 on cycles 1-4 after each push, in_ready stays 1.
- Skid fill: push A, B with out_ready=0 -> out_rs1=A held, in_ready=0 after B, stall_cnt counts 1,2,...; release out_ready -> A then B emerge, in_ready=1 again.
- Stall overrides ready: out_ready=1, stall=1 for 3 cycles with A held -> A held, stall_cnt +3, then A pops when stall=0.
- Flush with full skid plus in_valid same cycle -> next cycle out_valid=0, out_type=7, out_rd=0, incoming bundle never appears, in_ready=1.
- Counter saturation, CNT_W=2: hold for 6 cycles -> stall_cnt=3 and stays 3.

Source files
------------

// File: rtl/p3_exmem_elastic.sv
`default_nettype none
// p3_exmem_elastic: elastic EX/MEM stage with 2-entry skid buffer, flush and stall counter.
// Rev 1.0

module p3_exmem_elastic #(
   parameter int XLEN        = 32,
   parameter int TYPE_W      = 3,
   parameter int REG_W       = 5,
   parameter int BUBBLE_TYPE = 7,
   parameter int CNT_W       = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TYPE_W-1:0] in_type,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_store,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              stall,
   input  logic              flush,
   output logic [TYPE_W-1:0] out_type,
   output logic [XLEN-1:0]   out_rs1,
   output logic [XLEN-1:0]   out_rs2,
   output logic [REG_W-1:0]  out_rd,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_store,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int              c_PW       = TYPE_W + REG_W + 4 * XLEN;
   localparam logic [TYPE_W-1:0] c_BUBBLE = TYPE_W'(BUBBLE_TYPE);
   localparam logic [c_PW-1:0] c_BUBBLE_PKT = {c_BUBBLE, {(c_PW-TYPE_W){1'b0}}};
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   logic              r_m_v;
   logic              r_s_v;
   logic              r_in_ready;
   logic [c_PW-1:0]   r_m;
   logic [c_PW-1:0]   r_s;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_acc;
   logic              w_push;
   logic              w_pop;
   logic [c_PW-1:0]   w_in_pkt;

   assign w_acc    = out_ready & ~stall;
   assign w_push   = in_valid & r_in_ready;
   assign w_pop    = r_m_v & w_acc;
   assign w_in_pkt = {in_type, in_rs1, in_rs2, in_rd, in_imm, in_store};

   // Main entry: whenever it is empty it holds the bubble packet, so outputs never show stale data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_m_v <= 1'b0;
         r_m   <= c_BUBBLE_PKT;
      end else if (flush) begin
         r_m_v <= 1'b0;
         r_m   <= c_BUBBLE_PKT;
      end else if (!r_m_v || w_pop) begin
         if (r_m_v && r_s_v) begin
            r_m_v <= 1'b1;
            r_m   <= r_s;
         end else if (w_push) begin
            r_m_v <= 1'b1;
            r_m   <= w_in_pkt;
         end else begin
            r_m_v <= 1'b0;
            r_m   <= c_BUBBLE_PKT;
         end
      end
   end

   // Skid entry absorbs the one push that can land while M is blocked, since in_ready lags by a cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s_v      <= 1'b0;
         r_s        <= '0;
         r_in_ready <= 1'b1;
      end else if (flush) begin
         r_s_v      <= 1'b0;
         r_in_ready <= 1'b1;
      end else if (r_s_v && w_pop) begin
         r_s_v      <= 1'b0;
         r_in_ready <= 1'b1;
      end else if (r_m_v && !w_pop && w_push) begin
         r_s_v      <= 1'b1;
         r_s        <= w_in_pkt;
         r_in_ready <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (!flush && r_m_v && !w_acc && (r_stall_cnt != c_CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_m_v;
   assign {out_type, out_rs1, out_rs2, out_rd, out_imm, out_store} = r_m;
   assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
